// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator, X/Y stage 0, sync/colour stage 1.
// Optional VGA_TEST_PATTERN_EN replaces RGB with colour bars and a white border.
module vga_sync_gen #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 24,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic [2:0] RGB,
  output logic       hsync,
  output logic       vsync,
  output logic       red_vga,
  output logic       green_vga,
  output logic       blue_vga,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOT > 1023 || V_TOT > 1023) begin : g_bad_timing
      $error("vga_sync_gen: H_TOT/V_TOT must fit 10 bits");
    end
  endgenerate

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] hd_q, hd_d;
  logic [9:0] vd_q, vd_d;
  logic       vis0_q, vis0_d;
  logic       fs_q, fs_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       vis1_q, vis1_d;
  logic [2:0] col_q, col_d;

  // pixel/line counters: hcnt wraps each line, vcnt advances on wrap
  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  // stage 0: coordinates, visibility and frame pulse from the counters
  always_comb begin
    vis0_d = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    x_d    = vis0_d ? hcnt_q : 10'd0;
    y_d    = vis0_d ? vcnt_q : 10'd0;
    fs_d   = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    hd_d   = hcnt_q;
    vd_d   = vcnt_q;
  end

  // stage 1: syncs from the delayed counters, colour for the X/Y just shown
  always_comb begin
    hs_d   = !((hd_q >= HS_BEG) && (hd_q < HS_END));
    vs_d   = !((vd_q >= VS_BEG) && (vd_q < VS_END));
    vis1_d = vis0_q;
`ifdef VGA_TEST_PATTERN_EN
    if ((x_q == 10'd0) || (x_q == H_VIS - 10'd1) ||
        (y_q == 10'd0) || (y_q == V_VIS - 10'd1))
      col_d = 3'b111;
    else
      col_d = x_q[8:6];
`else
    col_d = RGB;
`endif
  end

`ifdef VGA_TEST_PATTERN_EN
  logic unused_rgb;
  assign unused_rgb = ^RGB;
`endif

  // all pipeline state, cleared asynchronously by clr
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      hd_q   <= '0;
      vd_q   <= '0;
      vis0_q <= 1'b0;
      fs_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      vis1_q <= 1'b0;
      col_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hd_q   <= hd_d;
      vd_q   <= vd_d;
      vis0_q <= vis0_d;
      fs_q   <= fs_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vis1_q <= vis1_d;
      col_q  <= col_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign frame_start = fs_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign {red_vga, green_vga, blue_vga} = vis1_q ? col_q : 3'b000;

endmodule
